// File: rtl/async_fifo_pkg.sv
// Shared constants and the occupancy encoding for the FIFO read-side framer.
// The occupancy step helper keeps the 2-entry buffer's bookkeeping in one place.
package async_fifo_pkg;

  localparam int DEFAULT_BITS    = 32;
  localparam int DEFAULT_PKT_LEN = 4;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_t;

  // A simultaneous write and read leaves the occupancy where it was.
  function automatic occ_t occ_step(occ_t occ, logic inc, logic dec);
    occ_t nxt;
    nxt = occ;
    if (inc && !dec) begin
      nxt = (occ == EMPTY) ? ONE : TWO;
    end else if (dec && !inc) begin
      nxt = (occ == TWO) ? ONE : EMPTY;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/stream_buf2.sv
// Two-entry circular skid buffer: registered head output, write at tail.
// Overflow and underflow are treated as design errors and asserted against.
module stream_buf2
  import async_fifo_pkg::*;
#(
  parameter int BITS = DEFAULT_BITS
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr,
  input  logic [BITS-1:0] wr_data,
  input  logic            rd,
  output logic [BITS-1:0] rd_data,
  output occ_t            occ
);

  logic [BITS-1:0] mem [2];
  logic            head;
  logic            tail;

  always_ff @(posedge clk) begin
    if (rst) begin
      occ  <= EMPTY;
      head <= 1'b0;
      tail <= 1'b0;
    end else begin
      occ <= occ_step(occ, wr, rd);
      if (wr) tail <= ~tail;
      if (rd) head <= ~head;
    end
  end

  // Storage needs no reset: the head is only exposed while occupancy is non-zero.
  always_ff @(posedge clk) begin
    if (wr && !rst) mem[tail] <= wr_data;
  end

  assign rd_data = mem[head];

  overflow_chk: assert property (@(posedge clk) disable iff (rst)
    !(wr && !rd && occ == TWO));

  underflow_chk: assert property (@(posedge clk) disable iff (rst)
    !(rd && occ == EMPTY));

endmodule

// File: rtl/fifo_read_framer.sv
// Pops words from an async FIFO read port into a 2-entry buffer and streams
// them out with a valid/ready handshake, marking packet ends and counting packets.
module fifo_read_framer
  import async_fifo_pkg::*;
#(
  parameter int BITS    = DEFAULT_BITS,
  parameter int PKT_LEN = DEFAULT_PKT_LEN
) (
  input  logic            clk,
  input  logic            rst,
  output logic            p_read_en,
  input  logic [BITS-1:0] p_read_data,
  input  logic            p_read_empty,
  output logic            p_out_valid,
  input  logic            p_out_ready,
  output logic [BITS-1:0] p_out_data,
  output logic            p_out_last,
  output logic [15:0]     p_pkt_count
);

  localparam logic [15:0] LAST_IDX = 16'(PKT_LEN - 1);

  occ_t            occ;
  logic [BITS-1:0] head_data;
  logic            inflight;
  logic            rst_q;
  logic            pop_out;
  logic [15:0]     word_cnt;
  logic [2:0]      fill;

  stream_buf2 #(.BITS(BITS)) u_buf (
    .clk     (clk),
    .rst     (rst),
    .wr      (inflight),
    .wr_data (p_read_data),
    .rd      (pop_out),
    .rd_data (head_data),
    .occ     (occ)
  );

  // Pop only if the word it brings is guaranteed a slot once it lands.
  always_comb begin
    p_out_valid = !rst && (occ != EMPTY);
    pop_out     = p_out_valid && p_out_ready;
    p_out_last  = p_out_valid && (word_cnt == LAST_IDX);
    p_out_data  = p_out_valid ? head_data : '0;
    fill        = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop_out};
    p_read_en   = !rst && !rst_q && !p_read_empty && (fill < 3'd2);
  end

  always_ff @(posedge clk) begin
    rst_q <= rst;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight    <= 1'b0;
      word_cnt    <= '0;
      p_pkt_count <= '0;
    end else begin
      inflight <= p_read_en;
      if (pop_out) begin
        word_cnt <= p_out_last ? 16'd0 : word_cnt + 16'd1;
        if (p_out_last) p_pkt_count <= p_pkt_count + 16'd1;
      end
    end
  end

endmodule

// File: doc/fifo_read_framer.md
FIFO_READ_FRAMER -- requirements
Module: fifo_read_framer

Interface
REQ-001 Parameter BITS, default 32: width of each data word; equals the upstream async_fifo BITS.
REQ-002 Parameter PKT_LEN, default 4: words per packet; legal range 1..65535.
REQ-003 Port clk  input  1: single clock; all logic on its rising edge (the read_clk domain of async_fifo).
REQ-004 Port rst  input  1: synchronous, active-high reset.
REQ-005 Port p_read_en  output  1: pop request to the async_fifo read port.
REQ-006 Port p_read_data  input  BITS: FIFO read data; valid one cycle after an accepted pop.
REQ-007 Port p_read_empty  input  1: FIFO empty flag; no pop is issued while it is 1.
REQ-008 Port p_out_valid  output  1: output word available.
REQ-009 Port p_out_ready  input  1: downstream accepts the word.
REQ-010 Port p_out_data  output  BITS: output word.
REQ-011 Port p_out_last  output  1: the current word closes a packet.
REQ-012 Port p_pkt_count  output  16: completed-packet counter; wraps modulo 2^16.

Function
REQ-013 A pop is accepted in cycle N when p_read_en=1 and p_read_empty=0; the popped word is on p_read_data in cycle N+1.
REQ-014 An internal 2-entry circular buffer holds words; occupancy states are EMPTY (0), ONE (1) and TWO (2); a 1-bit in-flight flag marks a pop issued last cycle.
REQ-015 Definition: pop_out = p_out_valid && p_out_ready.
REQ-016 Condition: p_read_en = !rst && !p_read_empty && (occ + inflight - pop_out) < 2.
REQ-017 A landing word is written into the buffer tail in the cycle after its pop; the buffer never overflows, and an overflow is an assertion failure.
REQ-018 Definition: p_out_valid = (occ != 0); p_out_data is registered buffer-head content, never combinational from p_read_data.
REQ-019 Latency: a pop in cycle N gives p_out_valid=1 in cycle N+2 at the earliest.
REQ-020 With p_out_ready held at 1 and the FIFO non-empty, throughput is one word per cycle.
REQ-021 Ordering: words leave in exact FIFO pop order; no drop and no duplication.
REQ-022 Hold rule: while p_out_valid=1 and p_out_ready=0, p_out_data and p_out_last hold stable.
REQ-023 A word counter (0..PKT_LEN-1) increments on each pop_out and wraps to 0 after the PKT_LEN-th word.
REQ-024 p_out_last = p_out_valid && (word counter == PKT_LEN-1); with PKT_LEN=1, every word is last.
REQ-025 p_pkt_count increments on pop_out with p_out_last=1; it wraps 65535 to 0.
REQ-026 Simultaneous land and pop_out in the same cycle leaves occupancy unchanged, and the head and tail pointers both advance.
REQ-027 If p_read_empty rises while a word is in flight, that word still lands; no further pop is issued.

Reset
REQ-028 Synchronous reset clears occupancy to EMPTY, the in-flight flag, both pointers, the word counter and p_pkt_count.
REQ-029 Outputs while rst=1 and in the cycle after: p_read_en=0, p_out_valid=0, p_out_last=0, p_out_data=0.
REQ-030 Reset mid-operation discards buffered and in-flight words; the next packet starts at word 0.

Structure
REQ-031 Package async_fifo_pkg holds DEFAULT_BITS, DEFAULT_PKT_LEN and typedef occ_t (EMPTY/ONE/TWO).
REQ-032 Sub-module stream_buf2: the 2-entry buffer with occupancy and pointers; fifo_read_framer adds pop control and packet counting.

Verification
REQ-033 Reset: rst=1 for 3 cycles with p_read_empty=0 -> p_read_en=0, p_out_valid=0, p_pkt_count=0.
REQ-034 Stream: FIFO holds 8 words 0..7, p_out_ready=1, PKT_LEN=4 -> words 0..7 on consecutive cycles; p_out_last on 3 and 7; p_pkt_count=2.
REQ-035 Backpressure: p_out_ready=0 for 10 cycles, FIFO holding 5 words -> exactly 2 pops, data stable at word 0; after ready=1 words 0..4 arrive in order.
REQ-036 Empty toggle: p_read_empty toggles every cycle with random p_out_ready for 1000 words -> scoreboard matches; no overflow assertion fires.
REQ-037 Mid-reset: rst pulsed after word 2 of a packet -> p_out_valid=0 next cycle; the next accepted word is counted as word 0.
REQ-038 Wrap: PKT_LEN=1 with 65537 words -> p_pkt_count=1.
